gbuf_arbiter: RTL and testbench

- Shares one single-port global buffer (A, B or P) between the TPU core and the host/DMA loader.
- The TPU has no stall input, so its port has absolute priority and zero added latency.
- The host uses a req/gnt handshake and is locked out from TPU start_i until the TPU's in-flight reads drain after valid_o.
- One instance per buffer; read data is steered back to the issuing requester through a latency-matched tag pipeline.

---
 rtl/gbuf_arbiter.sv | 171 +++++++++++++++++
 tb/tb_gbuf_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_arbiter.sv
// gbuf_arbiter: shares one single-port global buffer (A, B or P) between the
// TPU core and the host/DMA loader.
// The TPU port has absolute priority and no added latency. The host uses a
// req/gnt handshake and is locked out from TPU start until the TPU's reads
// drain after completion.
// Read data is steered back to the issuing requester by a tag pipeline whose
// depth matches the buffer read latency.
// Optional build macro: GBUF_ARB_STATS_EN adds host_stall_cnt_o, a saturating
// count of host wait cycles.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module gbuf_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tpu_start_i,
  input  logic                  tpu_valid_i,
  input  logic                  tpu_en_i,
  input  logic                  tpu_we_i,
  input  logic [ADDR_WIDTH-1:0] tpu_addr_i,
  input  logic [WORD_WIDTH-1:0] tpu_wdata_i,
  output logic [WORD_WIDTH-1:0] tpu_rdata_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [WORD_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic                  host_rvalid_o,
  output logic [WORD_WIDTH-1:0] host_rdata_o,
  output logic                  buf_en_o,
  output logic                  buf_we_o,
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  output logic [WORD_WIDTH-1:0] buf_wdata_o,
  input  logic [WORD_WIDTH-1:0] buf_rdata_i,
  output logic                  busy_o,
`ifdef GBUF_ARB_STATS_EN
  output logic [31:0]           host_stall_cnt_o,
`endif
  output logic                  conflict_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The drain counter counts down from RD_LAT-1 to 0, so FLUSH lasts RD_LAT cycles.
  localparam logic [2:0] DRAIN_INIT = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic [RD_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [RD_LAT-1:0] tag_host_q, tag_host_d;
  logic              host_gnt;
  logic              rd_issue;

  // Port mux: the TPU always wins, a granted host goes next, otherwise the buffer is idle.
  always_comb begin
    host_gnt    = host_req_i & ~tpu_en_i & (state_q == IDLE);
    buf_en_o    = 1'b0;
    buf_we_o    = 1'b0;
    buf_addr_o  = '0;
    buf_wdata_o = '0;
    if (tpu_en_i) begin
      buf_en_o    = 1'b1;
      buf_we_o    = tpu_we_i;
      buf_addr_o  = tpu_addr_i;
      buf_wdata_o = tpu_wdata_i;
    end else if (host_gnt) begin
      buf_en_o    = 1'b1;
      buf_we_o    = host_we_i;
      buf_addr_o  = host_addr_i;
      buf_wdata_o = host_wdata_i;
    end
    rd_issue = buf_en_o & ~buf_we_o;
  end

  // Lockout FSM: RUN blocks the host until TPU completion, and FLUSH drains the in-flight reads.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (tpu_start_i) state_d = RUN;
      end
      RUN: begin
        if (tpu_valid_i) begin
          state_d = FLUSH;
          drain_d = DRAIN_INIT;
        end
      end
      FLUSH: begin
        if (drain_q == 3'd0) state_d = IDLE;
        else drain_d = drain_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    conflict_d = conflict_q | (host_req_i & tpu_en_i & (state_q == IDLE));
  end

  // Tag pipeline: each issued read enters stage 0, tagged with its owner, and shifts toward the output.
  always_comb begin
    tag_valid_d    = '0;
    tag_host_d     = '0;
    tag_valid_d[0] = rd_issue;
    tag_host_d[0]  = rd_issue & ~tpu_en_i;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_host_d[i]  = tag_host_q[i-1];
    end
  end

  // State, status and tag registers; reset discards any read still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_q     <= 3'd0;
      busy_q      <= 1'b0;
      conflict_q  <= 1'b0;
      tag_valid_q <= '0;
      tag_host_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      conflict_q  <= conflict_d;
      tag_valid_q <= tag_valid_d;
      tag_host_q  <= tag_host_d;
    end
  end

  assign host_gnt_o    = host_gnt;
  assign host_rvalid_o = tag_valid_q[RD_LAT-1] & tag_host_q[RD_LAT-1];
  assign host_rdata_o  = host_rvalid_o ? buf_rdata_i : '0;
  assign tpu_rdata_o   = buf_rdata_i;
  assign busy_o        = busy_q;
  assign conflict_o    = conflict_q;

`ifdef GBUF_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of the cycles in which the host waits with a request pending.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (host_req_i && !host_gnt && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= 32'd0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign host_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gbuf_arbiter.sv
// tb_gbuf_arbiter: drives an RD_LAT=1 and an RD_LAT=2 gbuf_arbiter with the
// same stimulus. Each instance has its own buffer model. Outputs are compared
// against a phase/due-time reference model, directed vectors and
// hand-written sequences.
// Honours GBUF_ARB_STATS_EN when defined.

module tb_gbuf_arbiter;
  localparam int AW = 10;
  localparam int WW = 32;

  typedef struct {
    logic          rst;
    logic          start;
    logic          valid;
    logic          ten;
    logic          twe;
    logic [AW-1:0] taddr;
    logic [WW-1:0] twdata;
    logic          req;
    logic          hwe;
    logic [AW-1:0] haddr;
    logic [WW-1:0] hwdata;
  } stim_t;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic          exp_gnt;
    logic [1:0]    exp_rv;
    logic [WW-1:0] exp_rd0;
    logic [WW-1:0] exp_rd1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tpu_start = 1'b0, tpu_valid = 1'b0, tpu_en = 1'b0, tpu_we = 1'b0;
  logic [AW-1:0] tpu_addr = '0, host_addr = '0;
  logic [WW-1:0] tpu_wdata = '0, host_wdata = '0;
  logic          host_req = 1'b0, host_we = 1'b0;

  logic [WW-1:0] tpu_rdata [2];
  logic [WW-1:0] host_rdata [2];
  logic [WW-1:0] b_wdata [2];
  logic [WW-1:0] b_rdata [2];
  logic [AW-1:0] b_addr [2];
  logic          gnt [2], rvalid [2], b_en [2], b_we [2], busy [2], conflict [2];
`ifdef GBUF_ARB_STATS_EN
  logic [31:0]   stall_cnt [2];
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model state per instance.
  int            ph [2];
  int            rem [2];
  bit            conf [2];
  logic [31:0]   stall_ref [2];
  bit            eg [2];
  bit            pv [2][8];
  bit            phost [2][8];
  logic [WW-1:0] pdata [2][8];
  logic [WW-1:0] ref_mem [2][1<<AW];

  // Buffer models.
  logic [WW-1:0] bmem [2][1<<AW];
  logic [WW-1:0] bpipe [2][4];

  always #5 clk = ~clk;

  gbuf_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .RD_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .tpu_start_i(tpu_start), .tpu_valid_i(tpu_valid),
    .tpu_en_i(tpu_en), .tpu_we_i(tpu_we), .tpu_addr_i(tpu_addr), .tpu_wdata_i(tpu_wdata),
    .tpu_rdata_o(tpu_rdata[0]),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(gnt[0]), .host_rvalid_o(rvalid[0]), .host_rdata_o(host_rdata[0]),
    .buf_en_o(b_en[0]), .buf_we_o(b_we[0]), .buf_addr_o(b_addr[0]), .buf_wdata_o(b_wdata[0]),
    .buf_rdata_i(b_rdata[0]),
    .busy_o(busy[0]),
`ifdef GBUF_ARB_STATS_EN
    .host_stall_cnt_o(stall_cnt[0]),
`endif
    .conflict_o(conflict[0])
  );

  gbuf_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .RD_LAT(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .tpu_start_i(tpu_start), .tpu_valid_i(tpu_valid),
    .tpu_en_i(tpu_en), .tpu_we_i(tpu_we), .tpu_addr_i(tpu_addr), .tpu_wdata_i(tpu_wdata),
    .tpu_rdata_o(tpu_rdata[1]),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(gnt[1]), .host_rvalid_o(rvalid[1]), .host_rdata_o(host_rdata[1]),
    .buf_en_o(b_en[1]), .buf_we_o(b_we[1]), .buf_addr_o(b_addr[1]), .buf_wdata_o(b_wdata[1]),
    .buf_rdata_i(b_rdata[1]),
    .busy_o(busy[1]),
`ifdef GBUF_ARB_STATS_EN
    .host_stall_cnt_o(stall_cnt[1]),
`endif
    .conflict_o(conflict[1])
  );

  // Single-port buffer models with 1- and 2-cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (b_en[k] && b_we[k]) bmem[k][b_addr[k]] <= b_wdata[k];
      bpipe[k][0] <= (b_en[k] && !b_we[k]) ? bmem[k][b_addr[k]] : '0;
      for (int i = 1; i < 4; i++) bpipe[k][i] <= bpipe[k][i-1];
    end
  end
  assign b_rdata[0] = bpipe[0][0];
  assign b_rdata[1] = bpipe[1][1];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic stim_t zeroStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    cyc++;
    rst_n = !s.rst;
    if (s.rst) s = zeroStim();
    tpu_start  = s.start;
    tpu_valid  = s.valid;
    tpu_en     = s.ten;
    tpu_we     = s.twe;
    tpu_addr   = s.taddr;
    tpu_wdata  = s.twdata;
    host_req   = s.req;
    host_we    = s.hwe;
    host_addr  = s.haddr;
    host_wdata = s.hwdata;
  endtask

  task automatic checkOutput();
    #1;
    for (int k = 0; k < 2; k++) begin
      int            slot;
      int            ns;
      bit            idle, een, ewe;
      logic [AW-1:0] eaddr;
      logic [WW-1:0] ewd;
      slot = cyc % 8;
      if (!rst_n) begin
        chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
        chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
        chk($sformatf("rst_conflict%0d", k), 32'(conflict[k]), 32'd0);
`ifdef GBUF_ARB_STATS_EN
        chk($sformatf("rst_stall%0d", k), stall_cnt[k], 32'd0);
`endif
        ph[k] = 0; rem[k] = 0; conf[k] = 1'b0; stall_ref[k] = 32'd0; eg[k] = 1'b0;
        for (int s = 0; s < 8; s++) pv[k][s] = 1'b0;
      end else begin
        idle  = (ph[k] == 0);
        eg[k] = host_req && !tpu_en && idle;
        een   = tpu_en || eg[k];
        ewe   = tpu_en ? tpu_we : host_we;
        eaddr = tpu_en ? tpu_addr : host_addr;
        ewd   = tpu_en ? tpu_wdata : host_wdata;
        chk($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(eg[k]));
        chk($sformatf("buf_en%0d", k), 32'(b_en[k]), 32'(een));
        if (een) begin
          chk($sformatf("buf_we%0d", k), 32'(b_we[k]), 32'(ewe));
          chk($sformatf("buf_addr%0d", k), 32'(b_addr[k]), 32'(eaddr));
          if (ewe) chk($sformatf("buf_wdata%0d", k), b_wdata[k], ewd);
        end
        if (pv[k][slot]) begin
          if (phost[k][slot]) begin
            chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'd1);
            chk($sformatf("host_rdata%0d", k), host_rdata[k], pdata[k][slot]);
          end else begin
            chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'd0);
            chk($sformatf("tpu_rdata%0d", k), tpu_rdata[k], pdata[k][slot]);
          end
          pv[k][slot] = 1'b0;
        end else begin
          chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'd0);
        end
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(ph[k] != 0));
        chk($sformatf("conflict%0d", k), 32'(conflict[k]), 32'(conf[k]));
`ifdef GBUF_ARB_STATS_EN
        chk($sformatf("stall%0d", k), stall_cnt[k], stall_ref[k]);
`endif
        if (een && !ewe) begin
          ns = (cyc + lat(k)) % 8;
          pv[k][ns]    = 1'b1;
          phost[k][ns] = !tpu_en;
          pdata[k][ns] = ref_mem[k][eaddr];
        end
        if (een && ewe) ref_mem[k][eaddr] = ewd;
        if (host_req && tpu_en && idle) conf[k] = 1'b1;
        if (host_req && !eg[k] && stall_ref[k] != 32'hFFFF_FFFF) stall_ref[k]++;
        case (ph[k])
          0: if (tpu_start) ph[k] = 1;
          1: if (tpu_valid) begin ph[k] = 2; rem[k] = lat(k); end
          default: begin
            rem[k]--;
            if (rem[k] == 0) ph[k] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(zeroStim());
      checkOutput();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t s;
    vec_t  vecs [9];
    int    first [2];
    int    vcyc;
    int    rvseen;
    bit    hpend;
    stim_t hreq;

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < (1 << AW); a++) ref_mem[k][a] = '0;
      for (int sl = 0; sl < 8; sl++) pv[k][sl] = 1'b0;
      ph[k] = 0; rem[k] = 0; conf[k] = 1'b0; stall_ref[k] = 32'd0; eg[k] = 1'b0;
    end

    // Reset, then zero-fill the addresses used by random traffic.
    s = zeroStim(); s.rst = 1'b1;
    applyStimulus(s); checkOutput();
    applyStimulus(s); checkOutput();
    for (int a = 0; a < 32; a++) begin
      s = zeroStim(); s.req = 1'b1; s.hwe = 1'b1; s.haddr = AW'(a);
      applyStimulus(s); checkOutput();
    end

    // Idle host write/read vectors: {req, we, addr, wdata, gnt, rvalid{k1,k0}, rdata k0, rdata k1}.
    vecs[0] = '{1'b1, 1'b1, 10'h010, 32'h0000_00A5, 1'b1, 2'b00, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 10'h010, 32'h0,         1'b1, 2'b00, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 2'b01, 32'hA5, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 2'b10, 32'h0, 32'hA5};
    vecs[4] = '{1'b1, 1'b1, 10'h011, 32'h0000_005A, 1'b1, 2'b00, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 10'h011, 32'h0,         1'b1, 2'b00, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 10'h010, 32'h0,         1'b1, 2'b01, 32'h5A, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 2'b11, 32'hA5, 32'h5A};
    vecs[8] = '{1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 2'b10, 32'h0, 32'hA5};
    for (int i = 0; i < 9; i++) begin
      s = zeroStim();
      s.req = vecs[i].req; s.hwe = vecs[i].we; s.haddr = vecs[i].addr; s.hwdata = vecs[i].wdata;
      applyStimulus(s); checkOutput();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d_gnt%0d", i, k), 32'(gnt[k]), 32'(vecs[i].exp_gnt));
        chk($sformatf("vec%0d_busy%0d", i, k), 32'(busy[k]), 32'd0);
        chk($sformatf("vec%0d_rvalid%0d", i, k), 32'(rvalid[k]), 32'(vecs[i].exp_rv[k]));
        if (vecs[i].exp_rv[k])
          chk($sformatf("vec%0d_rdata%0d", i, k), host_rdata[k],
              (k == 0) ? vecs[i].exp_rd0 : vecs[i].exp_rd1);
      end
    end

    // Lockout: start, host waits through RUN and FLUSH, and is granted on the first IDLE cycle.
    idleCycles(3);
    s = zeroStim(); s.start = 1'b1;
    applyStimulus(s); checkOutput();
    first[0] = -1; first[1] = -1;
    hreq = zeroStim(); hreq.req = 1'b1; hreq.haddr = 10'h010;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(hreq); checkOutput();
      for (int k = 0; k < 2; k++) chk($sformatf("lock_run_gnt%0d", k), 32'(gnt[k]), 32'd0);
    end
    s = hreq; s.valid = 1'b1;
    applyStimulus(s); checkOutput();
    vcyc = cyc;
    for (int n = 0; n < 6; n++) begin
      applyStimulus(hreq); checkOutput();
      for (int k = 0; k < 2; k++) if (gnt[k] && first[k] < 0) first[k] = cyc;
    end
    for (int k = 0; k < 2; k++)
      chk($sformatf("lock_first_gnt%0d", k), 32'(first[k]), 32'(vcyc + lat(k) + 1));
    idleCycles(4);

    // TPU passthrough in RUN over preloaded words.
    for (int i = 0; i < 10; i++) begin
      s = zeroStim(); s.req = 1'b1; s.hwe = 1'b1;
      s.haddr = AW'(10'h100 + i); s.hwdata = 32'hC0DE_0100 + 32'(i);
      applyStimulus(s); checkOutput();
    end
    idleCycles(2);
    s = zeroStim(); s.start = 1'b1;
    applyStimulus(s); checkOutput();
    rvseen = 0;
    for (int i = 0; i < 13; i++) begin
      s = zeroStim();
      if (i < 10) begin s.ten = 1'b1; s.taddr = AW'(10'h100 + i); end
      applyStimulus(s); checkOutput();
      for (int k = 0; k < 2; k++) begin
        if (i < 10) chk($sformatf("pass_addr%0d", k), 32'(b_addr[k]), 32'h100 + 32'(i));
        if (i >= lat(k) && i - lat(k) < 10)
          chk($sformatf("pass_tpu_rdata%0d", k), tpu_rdata[k], 32'hC0DE_0100 + 32'(i - lat(k)));
        if (rvalid[k]) rvseen++;
      end
    end
    chk("pass_no_host_rvalid", 32'(rvseen), 32'd0);
    s = zeroStim(); s.valid = 1'b1;
    applyStimulus(s); checkOutput();
    idleCycles(4);

    // Collision in IDLE: TPU wins, conflict becomes sticky, host granted next free cycle.
    s = zeroStim(); s.req = 1'b1; s.haddr = 10'h010; s.ten = 1'b1; s.taddr = 10'h105;
    applyStimulus(s); checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("coll_addr%0d", k), 32'(b_addr[k]), 32'h105);
      chk($sformatf("coll_gnt%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("coll_conf_before%0d", k), 32'(conflict[k]), 32'd0);
    end
    s.ten = 1'b0;
    applyStimulus(s); checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("coll_gnt_next%0d", k), 32'(gnt[k]), 32'd1);
      chk($sformatf("coll_conf%0d", k), 32'(conflict[k]), 32'd1);
    end
    for (int n = 0; n < 3; n++) begin
      applyStimulus(zeroStim()); checkOutput();
      for (int k = 0; k < 2; k++) chk($sformatf("coll_sticky%0d", k), 32'(conflict[k]), 32'd1);
    end

    // In-flight crossover: host read granted, start on the following cycle.
    s = zeroStim(); s.req = 1'b1; s.hwe = 1'b1; s.haddr = 10'h020; s.hwdata = 32'hDEAD_0020;
    applyStimulus(s); checkOutput();
    idleCycles(2);
    s = zeroStim(); s.req = 1'b1; s.haddr = 10'h020;
    applyStimulus(s); checkOutput();
    s = zeroStim(); s.start = 1'b1;
    applyStimulus(s); checkOutput();
    chk("xover_rvalid0", 32'(rvalid[0]), 32'd1);
    chk("xover_rdata0", host_rdata[0], 32'hDEAD_0020);
    applyStimulus(zeroStim()); checkOutput();
    chk("xover_rvalid1", 32'(rvalid[1]), 32'd1);
    chk("xover_rdata1", host_rdata[1], 32'hDEAD_0020);
    s = zeroStim(); s.valid = 1'b1;
    applyStimulus(s); checkOutput();
    idleCycles(4);

    // Reset mid-RUN with host reads still in flight.
    s = zeroStim(); s.start = 1'b1; s.req = 1'b1; s.haddr = 10'h020;
    applyStimulus(s); checkOutput();
    s = zeroStim(); s.rst = 1'b1;
    applyStimulus(s); checkOutput();
    for (int k = 0; k < 2; k++) chk($sformatf("rstrun_busy%0d", k), 32'(busy[k]), 32'd0);
    applyStimulus(zeroStim()); checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rstrun_no_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("rstrun_idle%0d", k), 32'(busy[k]), 32'd0);
    end
    idleCycles(2);

    // Randomized traffic with a host that holds its request until granted.
    hpend = 1'b0;
    hreq = zeroStim();
    for (int n = 0; n < 3000; n++) begin
      s = zeroStim();
      s.rst    = ($urandom_range(0, 599) == 0);
      s.start  = ($urandom_range(0, 19) == 0);
      s.valid  = ($urandom_range(0, 9) == 0);
      s.ten    = ($urandom_range(0, 2) == 0);
      s.twe    = ($urandom_range(0, 3) == 0);
      s.taddr  = AW'($urandom_range(0, 31));
      s.twdata = $urandom;
      if (!hpend && $urandom_range(0, 2) == 0) begin
        hpend       = 1'b1;
        hreq.hwe    = ($urandom_range(0, 1) == 0);
        hreq.haddr  = AW'($urandom_range(0, 31));
        hreq.hwdata = $urandom;
      end
      s.req = hpend; s.hwe = hreq.hwe; s.haddr = hreq.haddr; s.hwdata = hreq.hwdata;
      applyStimulus(s); checkOutput();
      if (eg[0] || !rst_n) hpend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
